acc_add_ctrl: RTL
=================

// Module: acc_add_ctrl
// PURPOSE
//  Accumulator sequencer that drives an external WIDTH-bit ripple adder (a/b/ci in, sum/co out).
//  - Upstream: accepts op/operand commands over valid/ready.
//  - Downstream: returns the result and flags over valid/ready.
//  - Sits between the command source and the adder, registering operands and capturing sum/co.
// PARAMETERS
//  WIDTH   8    datapath width; must equal the external adder width
//  CNT_W   16   width of completed-operation counter
// PORTS
//  clk        in   1      single clock, all state rising-edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      command valid
//  in_ready   out  1      command accept
//  in_op      in   2      0=LOAD 1=ADD 2=ADC 3=SUB
//  in_data    in   WIDTH  operand
//  add_a      out  WIDTH  adder operand a
//  add_b      out  WIDTH  adder operand b
//  add_ci     out  1      adder carry-in
//  add_sum    in   WIDTH  adder sum (combinational from add_*)
//  add_co     in   1      adder carry-out
//  out_valid  out  1      result valid
//  out_ready  in   1      result accept
//  out_data   out  WIDTH  accumulator value
//  out_flags  out  4      {sat, ovf, zero, carry}
//  op_cnt     out  CNT_W  completed operations, wraps at 2^CNT_W
// BEHAVIOUR
//  - Clock/reset: one clock clk; reset rst_n asynchronous, active-low.
//  - Reset values: all outputs 0 except in_ready=1. Internal state: acc=0, carry=0, state=IDLE.
//  - FSM: IDLE -> EXEC -> RESP.
//    - IDLE: in_ready=1. On in_valid&in_ready, latch op/data; go EXEC.
//    - EXEC (exactly 1 cycle): in_ready=0; add_* driven from registered acc/op/data. At clock end:
//      acc<=result, flags<=new; go RESP.
//    - RESP: out_valid=1; out_data/out_flags stable until handshake.
//      - in_ready = out_ready.
//      - out handshake with in_valid=1: accept the new command in the same cycle; go EXEC.
//      - out handshake with in_valid=0: go IDLE.
//      - op_cnt++ on every out handshake.
//  - Timing: accept -> out_valid = 2 cycles. Back-to-back throughput is 1 op per 2 cycles.
//  - Adder drive in EXEC:
//    - LOAD: a=0, b=data, ci=0
//    - ADD:  a=acc, b=data, ci=0
//    - ADC:  a=acc, b=data, ci=carry
//    - SUB:  a=acc, b=~data, ci=1
//    - Outside EXEC: add_a=add_b=0, add_ci=0.
//  - Flags (all updated together in EXEC):
//    - carry = add_co. For SUB, carry=1 means no borrow.
//    - ovf = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]), using b as driven.
//    - zero = (acc_next==0).
//    - LOAD: carry=0, ovf=0, sat=0.
//  - Boundaries:
//    - in_valid held during EXEC is ignored: no accept, data not sampled.
//    - out_ready=0 stalls indefinitely in RESP with no state change.
//    - op_cnt wraps all-ones -> 0.
//    - rst_n low at any state: immediate return to reset values; in-flight command and result are dropped.
// CONFIGURATION
//  - Macro ACC_SAT_EN defined: unsigned saturation.
//    - ADD/ADC with add_co=1: acc<=all ones, sat=1.
//    - SUB with add_co=0 (borrow): acc<=0, sat=1.
//    - zero and carry are computed on the saturated acc / raw co.
//  - Macro ACC_SAT_EN undefined: results wrap modulo 2^WIDTH; sat is tied to 0.
// STRUCTURE
//  - Package acc_pkg: op codes OP_LOAD/OP_ADD/OP_ADC/OP_SUB, state encoding (IDLE/EXEC/RESP),
//    flag bit indices FLG_CARRY=0, FLG_ZERO=1, FLG_OVF=2, FLG_SAT=3.
//  - Sub-module acc_opnd_mux: combinational op -> {add_a, add_b, add_ci} select, gated by EXEC.
//  - The adder is external; the bench ties add_* to the team 8-bit ripple adder.
// TESTING
//  1. Reset then idle: rst_n pulse -> in_ready=1, out_valid=0, add_*=0, op_cnt=0.
//  2. LOAD 0x7F, ADD 0x01 -> out_data=0x80, flags ovf=1 carry=0 zero=0; op_cnt=2.
//  3. LOAD 0xFF, ADD 0x01, then ADC 0x00:
//     - ADD -> 0x00, carry=1, zero=1.
//     - ADC -> 0x01, carry=0.
//     - With ACC_SAT_EN the ADD gives 0xFF, sat=1.
//  4. LOAD 0x05, SUB 0x07 -> 0xFE, carry=0 (borrow). With ACC_SAT_EN -> 0x00, sat=1, zero=1.
//  5. Back-to-back with out_ready=1 and in_valid=1: 4 commands complete in 8 cycles.
//     Then out_ready=0 for 5 cycles: out_data and out_flags are stable and in_ready=0.
//  6. rst_n asserted during EXEC: outputs return to reset values next sample; no out_valid seen.
//     After release, LOAD 0x10 -> 0x10.

Source files
------------

// File: rtl/acc_pkg.sv
// Shared definitions for the accumulator sequencer.
//   op_e     : command op codes carried on in_op
//   state_e  : sequencer state encoding
//   FLG_*    : bit positions inside the 4-bit flags word {sat, ovf, zero, carry}
package acc_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_ADD  = 2'd1,
    OP_ADC  = 2'd2,
    OP_SUB  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int FLG_W     = 4;
  localparam int FLG_CARRY = 0;
  localparam int FLG_ZERO  = 1;
  localparam int FLG_OVF   = 2;
  localparam int FLG_SAT   = 3;

endpackage

// File: rtl/acc_opnd_mux.sv
// Operand select for the external adder.
// Ports:
//   exec    in   high only while the sequencer is in EXEC; gates all outputs
//   op      in   registered op code
//   acc     in   accumulator value
//   data    in   registered command operand
//   carry   in   stored carry flag (ADC carry-in)
//   add_a   out  adder operand a
//   add_b   out  adder operand b
//   add_ci  out  adder carry-in
import acc_pkg::*;

module acc_opnd_mux #(
  parameter int WIDTH = 8
) (
  input  logic             exec,
  input  op_e              op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] data,
  input  logic             carry,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (exec) begin
      unique case (op)
        OP_LOAD: begin
          add_b = data;
        end
        OP_ADD: begin
          add_a = acc;
          add_b = data;
        end
        OP_ADC: begin
          add_a  = acc;
          add_b  = data;
          add_ci = carry;
        end
        OP_SUB: begin
          // Two's-complement subtract: acc + ~data + 1.
          add_a  = acc;
          add_b  = ~data;
          add_ci = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/acc_add_ctrl.sv
// Accumulator sequencer driving an external WIDTH-bit adder.
// Accepts op/operand commands (valid/ready), runs one adder cycle in EXEC,
// and presents the accumulator plus flags (valid/ready) in RESP.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   command handshake; in_op (LOAD/ADD/ADC/SUB), in_data operand
//   add_a/add_b/add_ci  adder drive, zero outside EXEC
//   add_sum/add_co      adder result (combinational from add_*)
//   out_valid/out_ready result handshake; out_data accumulator, out_flags {sat,ovf,zero,carry}
//   op_cnt              completed operations (wraps)
// Configuration macro: ACC_SAT_EN enables unsigned saturation; otherwise results wrap
// and the sat flag is always 0.
import acc_pkg::*;

module acc_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_ci,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_co,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [FLG_W-1:0] out_flags,
  output logic [CNT_W-1:0] op_cnt
);

  localparam int MSB = WIDTH - 1;

  state_e           state, state_nxt;
  op_e              op_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] acc;
  logic [FLG_W-1:0] flags;
  logic             accept;
  logic             out_hs;
  logic [WIDTH-1:0] acc_nxt;
  logic [FLG_W-1:0] flags_nxt;
  logic             sat;
  logic             ovf;

  assign accept    = in_valid & in_ready;
  assign out_hs    = out_valid & out_ready;
  assign out_data  = acc;
  assign out_flags = flags;

  acc_opnd_mux #(.WIDTH(WIDTH)) u_opnd_mux (
    .exec   (state == EXEC),
    .op     (op_r),
    .acc    (acc),
    .data   (data_r),
    .carry  (flags[FLG_CARRY]),
    .add_a  (add_a),
    .add_b  (add_b),
    .add_ci (add_ci)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      state <= state_nxt;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = EXEC;
      end
      EXEC: begin
        state_nxt = RESP;
      end
      RESP: begin
        out_valid = 1'b1;
        // A new command can only enter when the current result leaves.
        in_ready  = out_ready;
        if (out_ready) state_nxt = in_valid ? EXEC : IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Result and flags from the adder output; only consumed in EXEC.
  always_comb begin
    acc_nxt   = add_sum;
    flags_nxt = '0;
    sat       = 1'b0;
    // Overflow judged on operands as driven, so SUB sees ~data.
    ovf       = (add_a[MSB] == add_b[MSB]) && (add_sum[MSB] != add_a[MSB]);
    unique case (op_r)
      OP_LOAD: begin
        ovf = 1'b0;
      end
      OP_ADD, OP_ADC: begin
`ifdef ACC_SAT_EN
        if (add_co) begin
          acc_nxt = '1;
          sat     = 1'b1;
        end
`endif
      end
      OP_SUB: begin
`ifdef ACC_SAT_EN
        // No carry-out on a subtract means a borrow occurred.
        if (!add_co) begin
          acc_nxt = '0;
          sat     = 1'b1;
        end
`endif
      end
    endcase
    flags_nxt[FLG_CARRY] = (op_r == OP_LOAD) ? 1'b0 : add_co;
    flags_nxt[FLG_ZERO]  = (acc_nxt == '0);
    flags_nxt[FLG_OVF]   = ovf;
    flags_nxt[FLG_SAT]   = sat;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r   <= OP_LOAD;
      data_r <= '0;
      acc    <= '0;
      flags  <= '0;
      op_cnt <= '0;
    end else begin
      if (accept) begin
        op_r   <= op_e'(in_op);
        data_r <= in_data;
      end
      if (state == EXEC) begin
        acc   <= acc_nxt;
        flags <= flags_nxt;
      end
      if (out_hs) begin
        op_cnt <= op_cnt + CNT_W'(1);
      end
    end
  end

endmodule
